// File: rtl/timer_input_cond.sv
// Input conditioner for the general timer: synchronizes and glitch-filters the
// raw capture and external-measure pins, then qualifies capture edges with hold-off.

module timer_input_cond_chan #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_raw,
  input  logic [FILT_W-1:0] i_filt_len,
  output logic              o_level
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_stable;
  logic [FILT_W-1:0]      r_cnt;

  logic                   w_sync;
  logic [FILT_W-1:0]      w_len;
  logic [FILT_W:0]        w_cnt_inc;
  logic                   w_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
    end
  end

  assign w_sync = r_sync[SYNC_STAGES-1];

  // A length of 0 behaves like 1; the compare is one bit wider so cnt+1 never wraps.
  assign w_len     = (i_filt_len == '0) ? {{(FILT_W-1){1'b0}}, 1'b1} : i_filt_len;
  assign w_cnt_inc = {1'b0, r_cnt} + {{FILT_W{1'b0}}, 1'b1};
  assign w_hit     = (w_cnt_inc >= {1'b0, w_len});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else if (w_sync == r_stable) begin
      r_cnt <= '0;
    end else if (w_hit) begin
      r_stable <= w_sync;
      r_cnt    <= '0;
    end else begin
      r_cnt <= (&r_cnt) ? r_cnt : w_cnt_inc[FILT_W-1:0];
    end
  end

  assign o_level = r_stable;

endmodule

module timer_input_cond #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 8,
  parameter int HOLD_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_i,
  input  logic              meas_raw_i,
  input  logic              cap_raw_i,
  input  logic [FILT_W-1:0] filt_len_i,
  input  logic [1:0]        cap_edge_i,
  input  logic [HOLD_W-1:0] holdoff_i,
  input  logic              cap_miss_clr_i,
  output logic              ext_meas_o,
  output logic              capture_o,
  output logic              cap_miss_o
);

  logic              w_stable_meas;
  logic              w_stable_cap;
  logic              r_cap_prev;
  logic              r_capture;
  logic              r_cap_miss;
  logic [HOLD_W-1:0] r_ho_cnt;

  logic              w_rise;
  logic              w_fall;
  logic              w_qual;
  logic              w_ho_busy;
  logic              w_accept;
  logic              w_drop;

  timer_input_cond_chan #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILT_W      (FILT_W)
  ) u_meas_chan (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_raw      (meas_raw_i),
    .i_filt_len (filt_len_i),
    .o_level    (w_stable_meas)
  );

  timer_input_cond_chan #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILT_W      (FILT_W)
  ) u_cap_chan (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_raw      (cap_raw_i),
    .i_filt_len (filt_len_i),
    .o_level    (w_stable_cap)
  );

  // The previous-value flop tracks even while disabled, so enabling never sees a stale edge.
  assign w_rise    = w_stable_cap & ~r_cap_prev;
  assign w_fall    = ~w_stable_cap & r_cap_prev;
  assign w_qual    = en_i & ((w_rise & cap_edge_i[0]) | (w_fall & cap_edge_i[1]));
  assign w_ho_busy = |r_ho_cnt;
  assign w_accept  = w_qual & ~w_ho_busy;
  assign w_drop    = w_qual & w_ho_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cap_prev <= 1'b0;
    end else begin
      r_cap_prev <= w_stable_cap;
    end
  end

  // capture_o is a one-cycle strobe with no back-pressure; the timer samples it every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_capture <= 1'b0;
      r_ho_cnt  <= '0;
    end else if (!en_i) begin
      r_capture <= 1'b0;
      r_ho_cnt  <= '0;
    end else begin
      r_capture <= w_accept;
      if (w_accept) begin
        r_ho_cnt <= holdoff_i;
      end else if (w_ho_busy) begin
        r_ho_cnt <= r_ho_cnt - {{(HOLD_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // A drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cap_miss <= 1'b0;
    end else if (w_drop) begin
      r_cap_miss <= 1'b1;
    end else if (cap_miss_clr_i) begin
      r_cap_miss <= 1'b0;
    end
  end

  assign ext_meas_o = w_stable_meas;
  assign capture_o  = r_capture;
  assign cap_miss_o = r_cap_miss;

endmodule
